// File: rtl/cordic_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cordic_engine                                                |
// | Purpose  : Iterative CORDIC engine, one micro-rotation per clock.       |
// |            Mode 0 (vectoring) returns magnitude and phase of (X,Y)      |
// |            over the full +/-180 degree range. Mode 1 (rotation) rotates |
// |            (X,Y) by angle Z. Outputs are gain compensated, rounded and  |
// |            saturated, with valid/ready handshakes on both sides.        |
// |                                                                         |
// | Ports    : CLK        in   clock, all state on rising edge              |
// |            RESET_N    in   asynchronous active-low reset                |
// |            In_Valid   in   operands valid                               |
// |            In_Ready   out  engine can accept operands (IDLE only)       |
// |            Mode       in   0 = vectoring, 1 = rotation                  |
// |            X_In/Y_In  in   signed DW-bit operands (I/Q)                 |
// |            Z_In       in   signed AW-bit binary angle (rotation only)   |
// |            Out_Valid  out  results valid, held until Out_Ready          |
// |            Out_Ready  in   downstream accepts results                   |
// |            X_Out      out  magnitude / rotated X                        |
// |            Y_Out      out  residual (~0) / rotated Y                    |
// |            Z_Out      out  phase / residual angle (~0)                  |
// |            Busy       out  high in any state other than IDLE            |
// |                                                                         |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module cordic_engine #(
  parameter int DW   = 13,
  parameter int GW   = 5,
  parameter int AW   = 16,
  parameter int ITER = 13
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          In_Valid,
  output logic          In_Ready,
  input  logic          Mode,
  input  logic [DW-1:0] X_In,
  input  logic [DW-1:0] Y_In,
  input  logic [AW-1:0] Z_In,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic [DW-1:0] X_Out,
  output logic [DW-1:0] Y_Out,
  output logic [AW-1:0] Z_Out,
  output logic          Busy
);

  // Datapath width: two integer headroom bits cover sqrt(2) times the
  // CORDIC gain of ~1.647 on a full-scale input.
  localparam int c_W  = DW + GW + 2;
  localparam int c_CW = $clog2(ITER);

  // Gain compensation 1/1.6467602 = 0.6072529 as a 16-bit fraction
  // (39797 / 65536). A constant product reduces to a shift-add tree.
  localparam int c_KW = 17;
  localparam int c_PW = c_W + c_KW;
  localparam int c_SH = 16 + GW;  // drop the K fraction and the guard bits together
  localparam logic signed [c_PW-1:0] c_K    = c_PW'(39797);
  localparam logic signed [c_PW-1:0] c_RND  = c_PW'(2 ** (c_SH - 1));
  localparam logic signed [c_PW-1:0] c_SMAX = c_PW'(2 ** (DW - 1) - 1);

  // Binary angle for 180 degrees (-2^(AW-1)); adding it flips the MSB.
  localparam logic [AW-1:0] c_Z180 = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ITER  = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic signed [c_W-1:0]   r_x;
  logic signed [c_W-1:0]   r_y;
  logic        [AW-1:0]    r_z;
  logic                    r_mode;
  logic        [c_CW-1:0]  r_iter;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;
  logic        [DW-1:0]    r_x_out;
  logic        [DW-1:0]    r_y_out;
  logic        [AW-1:0]    r_z_out;

  logic signed [c_W-1:0]   w_xs;
  logic signed [c_W-1:0]   w_ys;
  logic        [AW-1:0]    w_atan;
  logic                    w_dpos;
  logic                    w_rot_fold;

  // atan(2^-i) with 2^32 = 360 degrees.
  function automatic logic [31:0] atan32(input int idx);
    case (idx)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Round the 32-bit table entry to AW bits: (c * 2^AW + 2^31) / 2^32.
  // Everything is constant per index, so this folds into a small ROM.
  function automatic logic [AW-1:0] atan_aw(input int idx);
    return AW'((({32'd0, atan32(idx)} << AW) + 64'h0000_0000_8000_0000) >> 32);
  endfunction

  // Multiply by K, drop the guard bits with round-half-up, and clamp to a
  // symmetric range so the most negative code never appears on the output.
  function automatic logic [DW-1:0] scale_sat(input logic signed [c_W-1:0] v);
    logic signed [c_PW-1:0] p;
    p = (c_PW'(v) * c_K + c_RND) >>> c_SH;
    if (p > c_SMAX) begin
      return DW'(c_SMAX);
    end else if (p < -c_SMAX) begin
      return DW'(-c_SMAX);
    end else begin
      return DW'(p);
    end
  endfunction

  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_atan = atan_aw(int'(r_iter));

  // d = +1: vectoring drives a negative Y up to zero, rotation consumes a
  // non-negative residual angle.
  assign w_dpos = r_mode ? ~r_z[AW-1] : r_y[c_W-1];

  // Rotation angle outside [-90, +90): the top two bits differ.
  assign w_rot_fold = r_z[AW-1] ^ r_z[AW-2];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_mode      <= 1'b0;
      r_iter      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_z_out     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_iter <= '0;
          if (In_Valid) begin
            // Sign-extend by two headroom bits and append GW guard bits.
            r_x        <= {{2{X_In[DW-1]}}, X_In, {GW{1'b0}}};
            r_y        <= {{2{Y_In[DW-1]}}, Y_In, {GW{1'b0}}};
            r_z        <= Z_In;
            r_mode     <= Mode;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_PRE;
          end
        end

        S_PRE: begin
          // Fold the problem into the right half-plane so the iterations,
          // which converge over about +/-99.9 degrees, cover the full circle.
          if (!r_mode) begin
            if (r_x[c_W-1]) begin
              r_x <= -r_x;
              r_y <= -r_y;
              // +180 and -180 share one code in a wrapping binary angle.
              r_z <= c_Z180;
            end else begin
              r_z <= '0;
            end
          end else if (w_rot_fold) begin
            r_x <= -r_x;
            r_y <= -r_y;
            r_z <= r_z ^ c_Z180;
          end
          r_iter  <= '0;
          r_state <= S_ITER;
        end

        S_ITER: begin
          if (w_dpos) begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end else begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end
          if (r_iter == c_CW'(ITER - 1)) begin
            r_state <= S_SCALE;
          end else begin
            r_iter <= r_iter + c_CW'(1);
          end
        end

        S_SCALE: begin
          r_x_out     <= scale_sat(r_x);
          r_y_out     <= scale_sat(r_y);
          r_z_out     <= r_z;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          // Results stay registered until taken; new operands are only
          // accepted from the following cycle on.
          if (Out_Ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign In_Ready  = r_in_ready;
  assign Out_Valid = r_out_valid;
  assign Busy      = r_busy;
  assign X_Out     = r_x_out;
  assign Y_Out     = r_y_out;
  assign Z_Out     = r_z_out;

endmodule
`default_nettype wire

// File: doc/cordic_engine.md
Name: cordic_engine

Overview:
- Parametrised iterative CORDIC engine; one micro-rotation per clock.
- Supports two modes:
  - vectoring: magnitude and phase of (X,Y), full ±180° range.
  - rotation: rotate (X,Y) by angle Z.
- Gain-compensated, saturated outputs with valid/ready handshakes on input and output.
- Sits between the I/Q front end and downstream demod/phase-tracking logic.

Parameters:
- DW, 13, signed width of X/Y inputs and outputs.
- GW, 5, fractional guard bits appended internally.
- AW, 16, angle width; binary angle, 2^AW = 360°, signed two's complement (-2^(AW-1) = -180°).
- ITER, 13, micro-rotation count; legal 8..16.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- In_Valid  in  1  input operands valid.
- In_Ready  out  1  engine can accept operands.
- Mode  in  1  0 = vectoring, 1 = rotation; sampled on accept.
- X_In  in  DW  signed X / I.
- Y_In  in  DW  signed Y / Q.
- Z_In  in  AW  signed angle; used in rotation mode, ignored in vectoring.
- Out_Valid  out  1  results valid.
- Out_Ready  in  1  downstream accepts results.
- X_Out  out  DW  vectoring: magnitude; rotation: rotated X.
- Y_Out  out  DW  vectoring: residual (≈0); rotation: rotated Y.
- Z_Out  out  AW  vectoring: phase; rotation: residual angle (≈0).
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE, In_Ready=1, Out_Valid=0, Busy=0, X_Out/Y_Out/Z_Out=0, iteration counter=0. Reset mid-operation discards the operation.
- Internal datapath width: DW+GW+2 signed (headroom for √2 × gain 1.647). Inputs are sign-extended and left-shifted by GW. Shifts are arithmetic.
- FSM states: IDLE -> PRE -> ITER -> SCALE -> DONE -> IDLE.
- IDLE: In_Ready=1. When In_Valid=1, latch X, Y, Z and Mode, then go to PRE.
- PRE (1 cycle), quadrant fold:
  - Vectoring, X<0: negate X and Y; Z = +180° if Y≥0, else -180° (-2^(AW-1) for both; wraps). X≥0: Z=0.
  - Rotation, Z outside [-90°,+90°): negate X and Y, Z -= 180° (wrap modulo 2^AW).
- ITER (ITER cycles, counter i = 0..ITER-1):
  - Direction d: vectoring d = +1 if Y<0, else -1; rotation d = +1 if Z≥0, else -1.
  - Update: X -= d·(Y>>>i); Y += d·(X>>>i); Z -= d·atan(2^-i).
  - atan table: 16-entry constant, 32-bit precision, rounded to AW bits.
- SCALE (1 cycle):
  - X,Y multiplied by K = 0.607253 using a shift-add constant of ≥14 significant bits (error ≤ 1 LSB).
  - Drop GW bits with round-half-up, then saturate to [-(2^(DW-1)-1), 2^(DW-1)-1].
  - Register X_Out/Y_Out/Z_Out; Out_Valid=1.
- DONE: outputs held stable while Out_Valid=1 and Out_Ready=0. When Out_Ready=1: Out_Valid=0, go to IDLE. Out_Ready already high on entry: exactly one cycle in DONE.
- Latency: the accept edge is cycle 0; Out_Valid rises at cycle ITER+2. Minimum issue interval is ITER+4 cycles.
- Accept rules:
  - In_Valid while not IDLE is ignored: In_Ready=0, no queueing.
  - In_Valid in the same cycle as the DONE->IDLE transition is not accepted; acceptance is on the next cycle.
- Z arithmetic wraps modulo 2^AW: ±180° aliasing is legal, no saturation.
- Vectoring with X=Y=0: X_Out=0, Y_Out=0, Z_Out is a don't-care but deterministic.
- Accuracy, DW=13, AW=16, ITER=13: magnitude ±2 LSB, phase ±8 LSB.

Test Plan:
- Vectoring (1000,0) -> X_Out 1000±2, Z_Out 0±8; (0,1000) -> Z_Out 16384±8; (1000,1000) -> X_Out 1414±2, Z_Out 8192±8.
- Vectoring left half-plane: (-1000,0) -> X_Out 1000±2, Z_Out -32768±8 (wrap accepted); (-1000,-1000) -> Z_Out -24576±8; (-1000,1000) -> Z_Out 24576±8.
- Rotation (1000,0,Z=16384) -> X_Out 0±2, Y_Out 1000±2; (1000,0,Z=-24576) -> X_Out -707±2, Y_Out -707±2.
- Saturation: vectoring (4095,4095) -> X_Out 4095 exactly, Z_Out 8192±8; (-4095,-4095) -> X_Out 4095.
- Handshake: Out_Valid at cycle 15 after accept; hold Out_Ready=0 for 10 cycles -> outputs stable, In_Ready=0; In_Valid pulses during Busy are ignored; back-to-back transactions give a 17-cycle issue interval.
- RESET_N low asynchronously at iteration 5 -> all outputs 0 immediately, In_Ready=1 after release; the next transaction is correct and unaffected by the aborted one.
